// File: rtl/lsu_mem_stage_if.sv
// Execute, data-memory and writeback signal bundle of the load/store memory stage.
// slave is the stage's own view of the bundle; master is the surrounding pipeline and memory.
interface lsu_mem_stage_if #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned REG_ADDR_W = 5
);
    localparam int unsigned NB = XLEN / 8;

    logic                  ex_valid_i;
    logic                  ex_ready_o;
    logic [XLEN-1:0]       ex_alu_result_i;
    logic [XLEN-1:0]       ex_rs2_data_i;
    logic [REG_ADDR_W-1:0] ex_rd_i;
    logic                  ex_reg_wr_i;
    logic [XLEN-1:0]       ex_pc_pls4_i;
    logic [1:0]            ex_wb_sel_i;
    logic                  ex_mem_req_i;
    logic                  ex_mem_write_i;
    logic                  ex_mem_unsigned_i;
    logic [1:0]            ex_mem_nbytes_i;

    logic                  dmem_req_o;
    logic                  dmem_gnt_i;
    logic                  dmem_we_o;
    logic [XLEN-1:0]       dmem_addr_o;
    logic [NB-1:0]         dmem_be_o;
    logic [XLEN-1:0]       dmem_wdata_o;
    logic                  dmem_rvalid_i;
    logic [XLEN-1:0]       dmem_rdata_i;
    logic                  dmem_err_i;

    logic                  wb_valid_o;
    logic [XLEN-1:0]       wb_alu_out_o;
    logic [XLEN-1:0]       wb_load_data_o;
    logic [REG_ADDR_W-1:0] wb_rd_o;
    logic                  wb_reg_wr_o;
    logic [XLEN-1:0]       wb_pc_pls4_o;
    logic [1:0]            wb_sel_o;
    logic                  exc_valid_o;
    logic [2:0]            exc_cause_o;
    logic [XLEN-1:0]       exc_addr_o;

    modport slave (
        input  ex_valid_i, ex_alu_result_i, ex_rs2_data_i, ex_rd_i, ex_reg_wr_i,
               ex_pc_pls4_i, ex_wb_sel_i, ex_mem_req_i, ex_mem_write_i,
               ex_mem_unsigned_i, ex_mem_nbytes_i,
               dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i, dmem_err_i,
        output ex_ready_o,
               dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o,
               wb_valid_o, wb_alu_out_o, wb_load_data_o, wb_rd_o, wb_reg_wr_o,
               wb_pc_pls4_o, wb_sel_o, exc_valid_o, exc_cause_o, exc_addr_o
    );

    modport master (
        output ex_valid_i, ex_alu_result_i, ex_rs2_data_i, ex_rd_i, ex_reg_wr_i,
               ex_pc_pls4_i, ex_wb_sel_i, ex_mem_req_i, ex_mem_write_i,
               ex_mem_unsigned_i, ex_mem_nbytes_i,
               dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i, dmem_err_i,
        input  ex_ready_o,
               dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o,
               wb_valid_o, wb_alu_out_o, wb_load_data_o, wb_rd_o, wb_reg_wr_o,
               wb_pc_pls4_o, wb_sel_o, exc_valid_o, exc_cause_o, exc_addr_o
    );
endinterface

// File: rtl/lsu_mem_stage.sv
// Memory-stage load/store unit: req/gnt/rvalid data port, lane steering, load extension,
// misalignment/fault/timeout exceptions and a one-deep ready/stall towards execute.
module lsu_mem_stage #(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned REG_ADDR_W     = 5,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic           clk,
    input  logic           rstn,
    lsu_mem_stage_if.slave bus
);
    localparam int unsigned NB    = XLEN / 8;
    localparam int unsigned OFS_W = $clog2(NB);
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [2:0] C_LD_MIS = 3'd1;
    localparam logic [2:0] C_ST_MIS = 3'd2;
    localparam logic [2:0] C_LD_ERR = 3'd3;
    localparam logic [2:0] C_ST_ERR = 3'd4;
    localparam logic [2:0] C_TMO    = 3'd5;

    logic [1:0]            r_state, w_state_nxt;
    logic                  r_ready, r_req, r_we, r_uns;
    logic [XLEN-1:0]       r_addr, r_wdata;
    logic [NB-1:0]         r_be;
    logic [1:0]            r_size;
    logic [OFS_W-1:0]      r_off;
    logic [CNT_W-1:0]      r_cnt;
    logic [XLEN-1:0]       r_alu, r_pc4, r_ld, r_exc_addr;
    logic [REG_ADDR_W-1:0] r_rd;
    logic [1:0]            r_sel;
    logic                  r_pl_reg_wr;
    logic                  r_wb_valid, r_wb_reg_wr, r_exc_valid;
    logic [2:0]            r_exc_cause;

    logic                  w_take, w_launch, w_misal, w_timeout;
    logic                  w_fin, w_fin_exc, w_fin_reg_wr;
    logic [2:0]            w_fin_cause;
    logic [XLEN-1:0]       w_fin_addr;
    logic [OFS_W-1:0]      w_off;
    logic [NB-1:0]         w_be;
    logic [XLEN-1:0]       w_wdata, w_shift, w_ld_ext;
    logic                  w_sign;
    int unsigned           w_kept;

    assign w_off     = bus.ex_alu_result_i[OFS_W-1:0];
    assign w_take    = (r_state == S_IDLE) & bus.ex_valid_i;
    assign w_timeout = (r_cnt >= CNT_W'(TIMEOUT_CYCLES - 1));

    // Alignment check, byte enables and store-data lane replication for the incoming access
    always_comb begin
        w_misal = 1'b0;
        w_be    = '1;
        w_wdata = bus.ex_rs2_data_i;
        case (bus.ex_mem_nbytes_i)
            2'b00: begin
                w_be    = NB'(1) << w_off;
                w_wdata = {NB{bus.ex_rs2_data_i[7:0]}};
            end
            2'b01: begin
                w_misal = w_off[0];
                w_be    = NB'(3) << w_off;
                w_wdata = {(NB/2){bus.ex_rs2_data_i[15:0]}};
            end
            2'b10: begin
                w_misal = |w_off[1:0];
                w_be    = NB'(15) << w_off;
                w_wdata = {(NB/4){bus.ex_rs2_data_i[31:0]}};
            end
            default: begin
                w_misal = (XLEN == 32) ? 1'b1 : |bus.ex_alu_result_i[2:0];
            end
        endcase
    end

    // Next state and completion/exception decode
    always_comb begin
        w_state_nxt  = r_state;
        w_launch     = 1'b0;
        w_fin        = 1'b0;
        w_fin_exc    = 1'b0;
        w_fin_cause  = 3'd0;
        w_fin_reg_wr = r_pl_reg_wr;
        w_fin_addr   = r_alu;
        case (r_state)
            S_IDLE: begin
                w_fin_reg_wr = bus.ex_reg_wr_i;
                w_fin_addr   = bus.ex_alu_result_i;
                if (bus.ex_valid_i) begin
                    if (!bus.ex_mem_req_i) begin
                        w_fin = 1'b1;
                    end else if (w_misal) begin
                        w_fin       = 1'b1;
                        w_fin_exc   = 1'b1;
                        w_fin_cause = bus.ex_mem_write_i ? C_ST_MIS : C_LD_MIS;
                    end else begin
                        w_launch    = 1'b1;
                        w_state_nxt = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (bus.dmem_gnt_i) begin
                    w_state_nxt = S_RESP;
                end else if (w_timeout) begin
                    w_state_nxt = S_IDLE;
                    w_fin       = 1'b1;
                    w_fin_exc   = 1'b1;
                    w_fin_cause = C_TMO;
                end
            end
            S_RESP: begin
                if (bus.dmem_rvalid_i) begin
                    w_state_nxt = S_IDLE;
                    w_fin       = 1'b1;
                    if (bus.dmem_err_i) begin
                        w_fin_exc   = 1'b1;
                        w_fin_cause = r_we ? C_ST_ERR : C_LD_ERR;
                    end
                end else if (w_timeout) begin
                    w_state_nxt = S_IDLE;
                    w_fin       = 1'b1;
                    w_fin_exc   = 1'b1;
                    w_fin_cause = C_TMO;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Load extraction: shift the addressed lane down, then sign/zero extend above the access size
    always_comb begin
        w_shift = bus.dmem_rdata_i >> {r_off, 3'b000};
        w_kept  = XLEN;
        w_sign  = w_shift[XLEN-1];
        case (r_size)
            2'b00:   begin w_kept = 8;  w_sign = w_shift[7];  end
            2'b01:   begin w_kept = 16; w_sign = w_shift[15]; end
            2'b10:   begin w_kept = 32; w_sign = w_shift[31]; end
            default: begin w_kept = XLEN; w_sign = w_shift[XLEN-1]; end
        endcase
        w_sign   = w_sign & ~r_uns;
        w_ld_ext = '0;
        for (int i = 0; i < int'(XLEN); i++) begin
            w_ld_ext[i] = (i < int'(w_kept)) ? w_shift[i] : w_sign;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ready     <= 1'b1;
            r_req       <= 1'b0;
            r_we        <= 1'b0;
            r_uns       <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_be        <= '0;
            r_size      <= 2'd0;
            r_off       <= '0;
            r_cnt       <= '0;
            r_alu       <= '0;
            r_pc4       <= '0;
            r_rd        <= '0;
            r_sel       <= 2'd0;
            r_pl_reg_wr <= 1'b0;
            r_ld        <= '0;
            r_exc_addr  <= '0;
            r_exc_cause <= 3'd0;
            r_wb_valid  <= 1'b0;
            r_wb_reg_wr <= 1'b0;
            r_exc_valid <= 1'b0;
        end else begin
            r_ready     <= (w_state_nxt == S_IDLE);
            r_req       <= (w_state_nxt == S_REQ);
            r_wb_valid  <= w_fin;
            r_exc_valid <= w_fin & w_fin_exc;
            r_wb_reg_wr <= w_fin & ~w_fin_exc & w_fin_reg_wr;
            if (w_take) begin
                r_alu       <= bus.ex_alu_result_i;
                r_pc4       <= bus.ex_pc_pls4_i;
                r_rd        <= bus.ex_rd_i;
                r_sel       <= bus.ex_wb_sel_i;
                r_pl_reg_wr <= bus.ex_reg_wr_i;
            end
            if (w_launch) begin
                r_addr <= {bus.ex_alu_result_i[XLEN-1:OFS_W], OFS_W'(0)};
                r_be   <= w_be;
                r_wdata<= w_wdata;
                r_we   <= bus.ex_mem_write_i;
                r_size <= bus.ex_mem_nbytes_i;
                r_uns  <= bus.ex_mem_unsigned_i;
                r_off  <= w_off;
                r_cnt  <= '0;
            end else if ((r_state != S_IDLE) && (r_cnt != '1)) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_fin) begin
                r_exc_cause <= w_fin_exc ? w_fin_cause : 3'd0;
                r_exc_addr  <= w_fin_exc ? w_fin_addr : '0;
                r_ld        <= (w_fin_exc || (r_state == S_IDLE)) ? '0 : w_ld_ext;
            end
        end
    end

    assign bus.ex_ready_o     = r_ready;
    assign bus.dmem_req_o     = r_req;
    assign bus.dmem_we_o      = r_we;
    assign bus.dmem_addr_o    = r_addr;
    assign bus.dmem_be_o      = r_be;
    assign bus.dmem_wdata_o   = r_wdata;
    assign bus.wb_valid_o     = r_wb_valid;
    assign bus.wb_alu_out_o   = r_alu;
    assign bus.wb_load_data_o = r_ld;
    assign bus.wb_rd_o        = r_rd;
    assign bus.wb_reg_wr_o    = r_wb_reg_wr;
    assign bus.wb_pc_pls4_o   = r_pc4;
    assign bus.wb_sel_o       = r_sel;
    assign bus.exc_valid_o    = r_exc_valid;
    assign bus.exc_cause_o    = r_exc_cause;
    assign bus.exc_addr_o     = r_exc_addr;
endmodule
